// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Hazard/forwarding controller for the in-order RV pipeline.
//            Tracks in-flight register writers in a shift-register
//            scoreboard. Produces per-read-port forward selects, load-use
//            stall/bubble and taken-branch flush.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int NUM_RS     = 2,
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_STAGE = 1,
  parameter int FLUSH_CYC  = 1,
  localparam int SELW      = $clog2(FWD_STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [NUM_RS*REG_AW-1:0] id_rs,
  input  logic [NUM_RS-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]        id_rd,
  input  logic                     id_rf_wen,
  input  logic                     id_is_load,
  input  logic                     ex_br_taken,
  output logic [NUM_RS*SELW-1:0]   fwd_sel,
  output logic                     stall,
  output logic                     bubble,
  output logic                     flush,
  output logic [31:0]              stall_cnt
);

  // Flush counter only needs to hold FLUSH_CYC-2
  localparam int CNTW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'((FLUSH_CYC > 1) ? (FLUSH_CYC - 2) : 0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [FWD_STAGES-1:0] v_q;
  logic [FWD_STAGES-1:0] ld_q;
  logic [REG_AW-1:0] rd_q [FWD_STAGES];
  logic [31:0]       stall_cnt_q;

  logic w_hz;          // some port's youngest producer is a not-yet-ready load
  logic w_load_use;
  logic w_flush;
  logic w_push;

  // Forward select per port: youngest matching in-flight writer wins
  always_comb begin : p_fwd
    logic [REG_AW-1:0] rs;
    logic [SELW-1:0]   sel;
    logic              yld;
    fwd_sel = '0;
    w_hz    = 1'b0;
    for (int k = 0; k < NUM_RS; k++) begin
      rs  = id_rs[k*REG_AW +: REG_AW];
      sel = '0;
      yld = 1'b0;
      // Walk oldest to youngest so the youngest match overwrites
      for (int s = FWD_STAGES - 1; s >= 0; s--) begin
        if (id_rs_used[k] && v_q[s] && (rd_q[s] == rs) && (rs != '0)) begin
          sel = SELW'(s + 1);
          yld = ld_q[s] && (s < LOAD_STAGE);
        end
      end
      fwd_sel[k*SELW +: SELW] = sel;
      if (yld) begin
        w_hz = 1'b1;
      end
    end
  end

  // Flush FSM next-state; branch requests are ignored while already flushing
  always_comb begin : p_fsm
    state_d = state_q;
    cnt_d   = cnt_q;
    w_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_br_taken) begin
          w_flush = 1'b1;
          if (FLUSH_CYC > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_FLUSH: begin
        w_flush = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output combination: flush kills the ID instruction, so it overrides stall
  always_comb begin : p_out
    w_load_use = id_valid & w_hz;
    flush      = w_flush;
    stall      = w_load_use & ~w_flush;
    bubble     = w_flush | w_load_use;
    w_push     = id_valid & id_rf_wen & (id_rd != '0) & ~bubble;
    stall_cnt  = stall_cnt_q;
  end

  // Flush FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scoreboard shifts every cycle; stage 0 takes the advancing ID writer
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q  <= '0;
      ld_q <= '0;
      for (int s = 0; s < FWD_STAGES; s++) begin
        rd_q[s] <= '0;
      end
    end else begin
      for (int s = 1; s < FWD_STAGES; s++) begin
        v_q[s]  <= v_q[s-1];
        ld_q[s] <= ld_q[s-1];
        rd_q[s] <= rd_q[s-1];
      end
      v_q[0]  <= w_push;
      ld_q[0] <= w_push & id_is_load;
      rd_q[0] <= id_rd;
    end
  end

  // Saturating count of stall cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

endmodule
`default_nettype wire
